// File: rtl/au_serial_adder_ctrl_pkg.sv
// Shared AU definitions: nibble width of the lookahead slice and the
// controller state encodings.
package au_serial_adder_ctrl_pkg;

  localparam int AU_NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } au_state_e;

endpackage

// File: rtl/au_serial_adder_ctrl_lacg.sv
// 4-bit lookahead carry slice (LACG): purely combinational sum and carry-out
// from generate/propagate terms.
module au_serial_adder_ctrl_lacg
  import au_serial_adder_ctrl_pkg::*;
(
  input  logic [AU_NIB_W-1:0] a,
  input  logic [AU_NIB_W-1:0] b,
  input  logic                ci,
  output logic [AU_NIB_W-1:0] s,
  output logic                co
);

  logic [AU_NIB_W-1:0] g, p, c;

  assign g = a & b;
  assign p = a ^ b;

  // All carries are flattened from ci so none of them ripple.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule

// File: rtl/au_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract built on one 4-bit LACG slice, one nibble per
// clock LSB first, with valid/ready start and result handshakes.
module au_serial_adder_ctrl
  import au_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / AU_NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  au_state_e            state, state_nxt;
  logic [WIDTH-1:0]     a_r, b_r;
  logic                 carry_r;
  logic [IDX_W-1:0]     idx;
  logic [AU_NIB_W-1:0]  nib_a, nib_b, nib_s;
  logic                 nib_c;
  logic                 accept, last;

  assign accept = (state == ST_IDLE) & start_valid & ~clr;
  assign last   = (idx == LAST_IDX);
  assign nib_a  = a_r[idx*AU_NIB_W +: AU_NIB_W];
  assign nib_b  = b_r[idx*AU_NIB_W +: AU_NIB_W];

  au_serial_adder_ctrl_lacg u_lacg (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_r),
    .s  (nib_s),
    .co (nib_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_valid) state_nxt = ST_RUN;
        ST_RUN:  if (last)        state_nxt = ST_DONE;
        ST_DONE: if (res_ready)   state_nxt = ST_IDLE;
        default:                  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake/status outputs decode straight from the state flops.
  assign start_ready = (state == ST_IDLE);
  assign busy        = (state == ST_RUN);
  assign res_valid   = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (clr) begin
      if (state == ST_RUN) begin
        result <= '0;
        cout   <= 1'b0;
        ovf    <= 1'b0;
      end
    end else if (accept) begin
      // Subtract is a + ~b + 1, so the operand is inverted once at capture.
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : cin;
      idx     <= '0;
      result  <= '0;
    end else if (state == ST_RUN) begin
      result[idx*AU_NIB_W +: AU_NIB_W] <= nib_s;
      carry_r <= nib_c;
      idx     <= idx + 1'b1;
      if (last) begin
        cout <= nib_c;
        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (nib_s[AU_NIB_W-1] != a_r[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_au_serial_adder_ctrl.sv
// Directed bench for the serial adder controller: arithmetic corners, latency,
// backpressure, abort, async reset and back-to-back issue.
module tb_au_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clr, start_valid, start_ready, sub, cin;
  logic        res_valid, res_ready, cout, ovf, busy;
  logic [15:0] a, b, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  au_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for res_valid after an accept edge; returns edges counted.
  task automatic wait_valid(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ts, input logic tc, input logic [15:0] er,
                        input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; sub = ~ts; cin = ~tc;
    chk({tag, "_busy"}, busy, 1);
    wait_valid(n);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_hs_valid"}, res_valid, 0);
    chk({tag, "_hs_ready"}, start_ready, 1);
  endtask

  logic [15:0] va [3];
  logic [15:0] vb [3];
  logic [15:0] ver[3];
  logic        vs [3];
  logic        vec[3];
  logic        veo[3];
  int          acc[3];

  initial begin
    int n, k, r, cyc;
    rst_n = 1'b0; clr = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #2;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",    16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub1",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: result must hold and new operands must wait.
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; sub = 1'b0; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_valid(n);
    chk("bp_latency", n, 4);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; start_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_result", result, 16'h0300);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_start_ready", start_ready, 0);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_valid", res_valid, 0);
    chk("bp_hs_start_ready", start_ready, 1);
    chk("bp_hs_result", result, 16'h0300);
    @(negedge clk); res_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_accept_busy", busy, 1);
    start_valid = 1'b0;
    wait_valid(n);
    chk("bp2_latency", n, 4);
    chk("bp2_result", result, 16'h3333);
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    run_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Abort on the second RUN cycle; a simultaneous start is ignored.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111; sub = 1'b0; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_partial", result, 16'h000B);
    @(negedge clk);
    clr = 1'b1; start_valid = 1'b1; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    chk("clr_busy", busy, 0);
    chk("clr_start_ready", start_ready, 1);
    chk("clr_result", result, 0);
    chk("clr_cout", cout, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_res_valid", res_valid, 0);
    @(negedge clk); clr = 1'b0; start_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("clr_no_valid", res_valid, 0);
    chk("clr_idle", start_ready, 1);

    // Async reset mid-RUN after an op that left cout/ovf set.
    run_op("pre", 16'h9000, 16'h9000, 1'b0, 1'b0, 16'h2000, 1'b1, 1'b1);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_partial", result, 16'h0045);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start_ready", start_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("one", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with start_valid and res_ready held high.
    va[0] = 16'h0010; vb[0] = 16'h0020; vs[0] = 1'b0; ver[0] = 16'h0030; vec[0] = 1'b0; veo[0] = 1'b0;
    va[1] = 16'h9000; vb[1] = 16'h9000; vs[1] = 1'b0; ver[1] = 16'h2000; vec[1] = 1'b1; veo[1] = 1'b1;
    va[2] = 16'h0003; vb[2] = 16'h0005; vs[2] = 1'b1; ver[2] = 16'hFFFE; vec[2] = 1'b0; veo[2] = 1'b0;
    res_ready = 1'b1; k = 0; r = 0; cyc = 0;
    while (r < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        chk("b2b_result", result, ver[r]);
        chk("b2b_cout", cout, vec[r]);
        chk("b2b_ovf", ovf, veo[r]);
        r++;
      end
      start_valid = (k < 3);
      if (k < 3) begin
        a = va[k]; b = vb[k]; sub = vs[k]; cin = 1'b0;
        if (start_ready) begin
          acc[k] = cyc;
          k++;
        end
      end
    end
    start_valid = 1'b0; res_ready = 1'b0;
    chk("b2b_count", r, 3);
    // accept, NIB run edges, handshake edge, then the next accept
    chk("b2b_interval01", acc[1] - acc[0], 6);
    chk("b2b_interval12", acc[2] - acc[1], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
